// File: rtl/handshake_buf_top.sv
// handshake_buf_top: master/slave enable handshake with a DEPTH-entry elastic
// buffer. The master side pushes generated sequence words; the slave side pops
// them onto a registered output with a one-cycle valid strobe.
module handshake_buf_top #(
  parameter int              WIDTH = 8,
  parameter int              DEPTH = 4,
  parameter logic [WIDTH-1:0] INIT  = '0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     m_en,
  input  logic                     s_en,
  output logic [WIDTH-1:0]         data_out,
  output logic                     data_vld,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     m_stall
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;
  logic [WIDTH-1:0] gen_cnt;
  logic             push, pop;

  // Status comes from registered pointers only; the MSB is the wrap bit.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign level   = wr_ptr - rd_ptr;
  assign push    = m_en & ~full;
  assign pop     = s_en & ~empty;
  assign m_stall = m_en & full;

  // Pointers, generator and output register; refused requests are dropped.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      gen_cnt  <= INIT;
      data_out <= '0;
      data_vld <= 1'b0;
    end else begin
      data_vld <= pop;
      if (push) begin
        wr_ptr  <= wr_ptr + 1'b1;
        gen_cnt <= gen_cnt + 1'b1;
      end
      if (pop) begin
        rd_ptr   <= rd_ptr + 1'b1;
        data_out <= mem[rd_ptr[AW-1:0]];
      end
    end
  end

  // Storage array is not reset; empty masks stale contents.
  always_ff @(posedge clk) begin
    if (rst_n && push) mem[wr_ptr[AW-1:0]] <= gen_cnt;
  end
endmodule

// File: tb/tb_handshake_buf_top.sv
// Directed bench: a vector table for fill/drain/stream/collision plus
// hand-written sequences for value wrap, pointer wrap and mid-operation reset.
module tb_handshake_buf_top;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0, m_en = 1'b0, s_en = 1'b0;
  logic [7:0] dout, dout_w;
  logic       vld, vld_w, full, full_w, empty, empty_w, stall, stall_w;
  logic [2:0] level, level_w;
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  handshake_buf_top #(.WIDTH(8), .DEPTH(4), .INIT(8'h00)) u_dut (
    .clk(clk), .rst_n(rst_n), .m_en(m_en), .s_en(s_en),
    .data_out(dout), .data_vld(vld), .full(full), .empty(empty),
    .level(level), .m_stall(stall));

  handshake_buf_top #(.WIDTH(8), .DEPTH(4), .INIT(8'hFE)) u_wrap (
    .clk(clk), .rst_n(rst_n), .m_en(m_en), .s_en(s_en),
    .data_out(dout_w), .data_vld(vld_w), .full(full_w), .empty(empty_w),
    .level(level_w), .m_stall(stall_w));

  typedef struct {
    logic r, m, s;      // stimulus
    logic st;           // m_stall before the edge
    int   lvl;          // outputs after the edge
    logic f, e, v;
    logic [7:0] d;
  } vec_t;
  vec_t tv[$];

  function automatic vec_t mk(logic r, logic m, logic s, logic st, int lvl,
                              logic f, logic e, logic v, logic [7:0] d);
    vec_t t;
    t.r = r; t.m = m; t.s = s; t.st = st; t.lvl = lvl;
    t.f = f; t.e = e; t.v = v; t.d = d;
    return t;
  endfunction

  task automatic chk(string name, int act, int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // drive at the falling edge, settle combinational outputs
  task automatic drive(logic r, logic m, logic s);
    @(negedge clk);
    rst_n = r; m_en = m; s_en = s;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    //            r  m  s  st lvl f  e  v  d
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 8'h00)); // reset
    tv.push_back(mk(1, 1, 0, 0, 1, 0, 0, 0, 8'h00)); // fill
    tv.push_back(mk(1, 1, 0, 0, 2, 0, 0, 0, 8'h00));
    tv.push_back(mk(1, 1, 0, 0, 3, 0, 0, 0, 8'h00));
    tv.push_back(mk(1, 1, 0, 0, 4, 1, 0, 0, 8'h00));
    tv.push_back(mk(1, 1, 0, 1, 4, 1, 0, 0, 8'h00)); // 5th push refused
    tv.push_back(mk(1, 0, 1, 0, 3, 0, 0, 1, 8'h00)); // drain
    tv.push_back(mk(1, 0, 1, 0, 2, 0, 0, 1, 8'h01));
    tv.push_back(mk(1, 0, 1, 0, 1, 0, 0, 1, 8'h02));
    tv.push_back(mk(1, 0, 1, 0, 0, 0, 1, 1, 8'h03));
    tv.push_back(mk(1, 0, 1, 0, 0, 0, 1, 0, 8'h03)); // pop on empty, hold
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 8'h00)); // reset
    tv.push_back(mk(1, 1, 1, 0, 1, 0, 0, 0, 8'h00)); // stream: push only
    tv.push_back(mk(1, 1, 1, 0, 1, 0, 0, 1, 8'h00));
    tv.push_back(mk(1, 1, 1, 0, 1, 0, 0, 1, 8'h01));
    tv.push_back(mk(1, 1, 1, 0, 1, 0, 0, 1, 8'h02));
    tv.push_back(mk(1, 1, 1, 0, 1, 0, 0, 1, 8'h03));
    tv.push_back(mk(1, 1, 1, 0, 1, 0, 0, 1, 8'h04));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 8'h00)); // reset
    tv.push_back(mk(1, 1, 0, 0, 1, 0, 0, 0, 8'h00)); // fill for collision
    tv.push_back(mk(1, 1, 0, 0, 2, 0, 0, 0, 8'h00));
    tv.push_back(mk(1, 1, 0, 0, 3, 0, 0, 0, 8'h00));
    tv.push_back(mk(1, 1, 0, 0, 4, 1, 0, 0, 8'h00));
    tv.push_back(mk(1, 1, 1, 1, 3, 0, 0, 1, 8'h00)); // full: pop only
    tv.push_back(mk(1, 1, 1, 0, 3, 0, 0, 1, 8'h01)); // push+pop

    foreach (tv[i]) begin
      drive(tv[i].r, tv[i].m, tv[i].s);
      chk($sformatf("v%0d m_stall", i), int'(stall), int'(tv[i].st));
      tick();
      chk($sformatf("v%0d level", i), int'(level), tv[i].lvl);
      chk($sformatf("v%0d full", i), int'(full), int'(tv[i].f));
      chk($sformatf("v%0d empty", i), int'(empty), int'(tv[i].e));
      chk($sformatf("v%0d data_vld", i), int'(vld), int'(tv[i].v));
      chk($sformatf("v%0d data_out", i), int'(dout), int'(tv[i].d));
    end

    // value wrap on the INIT=0xFE instance
    drive(0, 0, 0); tick();
    for (int i = 0; i < 3; i++) begin drive(1, 1, 0); tick(); end
    chk("wrap level", int'(level_w), 3);
    for (int i = 0; i < 3; i++) begin
      logic [7:0] e;
      e = 8'hFE + 8'(i);
      drive(1, 0, 1); tick();
      chk($sformatf("wrap pop%0d data_out", i), int'(dout_w), int'(e));
      chk($sformatf("wrap pop%0d data_vld", i), int'(vld_w), 1);
    end

    // pointer wrap: 10 words one at a time
    drive(0, 0, 0); tick();
    for (int i = 0; i < 10; i++) begin
      drive(1, 1, 0); tick();
      chk($sformatf("pw%0d level after push", i), int'(level), 1);
      drive(1, 0, 1); tick();
      chk($sformatf("pw%0d data_out", i), int'(dout), i);
      chk($sformatf("pw%0d empty", i), int'(empty), 1);
    end

    // mid-operation reset
    drive(0, 0, 0); tick();
    for (int i = 0; i < 3; i++) begin drive(1, 1, 0); tick(); end
    drive(1, 0, 1); tick();
    chk("mr pre level", int'(level), 2);
    chk("mr pre data_vld", int'(vld), 1);
    drive(0, 1, 1); tick();
    chk("mr level", int'(level), 0);
    chk("mr empty", int'(empty), 1);
    chk("mr data_out", int'(dout), 0);
    chk("mr data_vld", int'(vld), 0);
    drive(1, 1, 0); tick();
    drive(1, 0, 1); tick();
    chk("mr first word", int'(dout), 8'h00);
    chk("mr first word wrap inst", int'(dout_w), 8'hFE);
    chk("mr first vld", int'(vld), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
